// File: rtl/heading_smoother_if.sv
// Sample/handshake bundle between the heading calculator and the display path.
interface heading_smoother_if;
  logic [8:0] heading_in;
  logic       heading_valid;
  logic       in_ready;
  logic [8:0] heading_out;
  logic       out_valid;
  logic       stale;

  modport master (
    output heading_in, heading_valid,
    input  in_ready, heading_out, out_valid, stale
  );

  modport slave (
    input  heading_in, heading_valid,
    output in_ready, heading_out, out_valid, stale
  );
endinterface

// File: rtl/heading_smoother.sv
// Circular EMA heading smoother with deadband and stale-sample timeout.
// Output heading stays in 0..359 and steps the short way across 359/0.
module heading_smoother #(
  parameter int unsigned SHIFT          = 2,
  parameter int unsigned DEADBAND       = 1,
  parameter int unsigned TIMEOUT_CYCLES = 10000000,
  parameter int unsigned CNT_W          = 24
) (
  input  logic              clk,
  input  logic              reset,
  heading_smoother_if.slave hs
);

  typedef enum logic [1:0] {INIT, IDLE, DIFF, UPDATE} state_t;

  localparam logic [CNT_W-1:0]  TIMEOUT = CNT_W'(TIMEOUT_CYCLES);
  localparam logic signed [11:0] DB     = 12'(DEADBAND);
  localparam logic signed [11:0] P179   = 12'sd179;
  localparam logic signed [11:0] N180   = -12'sd180;
  localparam logic signed [11:0] P360   = 12'sd360;

  state_t           state_q, state_d;
  logic [8:0]       heading_q, heading_d;
  logic [8:0]       sample_q, sample_d;
  logic             out_valid_q, out_valid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             ready;
  logic             accept;
  logic signed [11:0] diff, err, abs_err, shifted, step, sum, wrapped;
  logic             in_deadband;

  assign ready  = (state_q == INIT) || (state_q == IDLE);
  assign accept = hs.heading_valid && ready && (hs.heading_in <= 9'd359);

  // Wrapped error, EMA step and wrapped sum for the latched sample
  always_comb begin
    diff = $signed({3'b000, sample_q}) - $signed({3'b000, heading_q});
    if (diff > P179)      err = diff - P360;
    else if (diff < N180) err = diff + P360;
    else                  err = diff;
    abs_err     = (err < 0) ? -err : err;
    in_deadband = (abs_err <= DB);
    shifted     = err >>> SHIFT;
    if (shifted == '0) step = (err < 0) ? -12'sd1 : 12'sd1;
    else               step = shifted;
    sum = $signed({3'b000, heading_q}) + step;
    if (sum >= P360)   wrapped = sum - P360;
    else if (sum < 0)  wrapped = sum + P360;
    else               wrapped = sum;
  end

  // Next-state logic; the new heading is registered on the DIFF->UPDATE
  // edge so that heading_out and out_valid are both visible in UPDATE,
  // two cycles after the accept.
  always_comb begin
    state_d     = state_q;
    heading_d   = heading_q;
    sample_d    = sample_q;
    out_valid_d = 1'b0;
    unique case (state_q)
      INIT: if (accept) begin
        heading_d   = hs.heading_in;
        out_valid_d = 1'b1;
        state_d     = IDLE;
      end
      IDLE: if (accept) begin
        sample_d = hs.heading_in;
        state_d  = DIFF;
      end
      DIFF: begin
        if (!in_deadband) heading_d = wrapped[8:0];
        out_valid_d = 1'b1;
        state_d     = UPDATE;
      end
      UPDATE: state_d = IDLE;
      default: state_d = INIT;
    endcase
  end

  // Timeout counter: cleared on accept, otherwise saturating increment
  always_comb begin
    cnt_d = cnt_q;
    if (accept)               cnt_d = '0;
    else if (cnt_q != TIMEOUT) cnt_d = cnt_q + CNT_W'(1);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= INIT;
      heading_q   <= '0;
      sample_q    <= '0;
      out_valid_q <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      heading_q   <= heading_d;
      sample_q    <= sample_d;
      out_valid_q <= out_valid_d;
      cnt_q       <= cnt_d;
    end
  end

  assign hs.in_ready    = ready;
  assign hs.heading_out = heading_q;
  assign hs.out_valid   = out_valid_q;
  assign hs.stale       = (cnt_q == TIMEOUT);

endmodule

// File: tb/tb_heading_smoother.sv
// Bench for heading_smoother: directed scenarios with literal expectations
// plus randomized traffic, all compared against a cycle-level model.
module tb_heading_smoother;
  localparam int T  = 50;
  localparam int SH = 2;
  localparam int DB = 1;

  logic clk = 1'b0;
  logic rst = 1'b1;

  heading_smoother_if hs();

  heading_smoother #(
    .SHIFT(SH), .DEADBAND(DB), .TIMEOUT_CYCLES(T), .CNT_W(8)
  ) dut (
    .clk(clk), .reset(rst), .hs(hs)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  // Model: current heading, pending result, cycles until ready again,
  // cycles since last accept, and whether the first sample is still due.
  int m_h = 0, m_pend = 0, m_busy = 0, m_cnt = 0;
  bit m_init = 1'b1, m_ov = 1'b0, m_acc;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Shortest-way error in -180..179, floor-divided step, wrapped result
  function automatic int smooth(input int h, input int s);
    int e, d, st;
    d = 1 << SH;
    e = ((s - h + 540) % 360) - 180;
    if (e >= -DB && e <= DB) return h;
    if (e >= 0) st = e / d;
    else        st = -((-e + d - 1) / d);
    if (st == 0) st = (e > 0) ? 1 : -1;
    return (h + st + 360) % 360;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_h = 0; m_pend = 0; m_busy = 0; m_cnt = 0; m_init = 1'b1; m_ov = 1'b0;
    end else begin
      m_acc = hs.heading_valid && (m_busy == 0) && (int'(hs.heading_in) <= 359);
      m_ov  = 1'b0;
      if (m_busy == 2) begin m_h = m_pend; m_ov = 1'b1; end
      if (m_busy > 0) m_busy--;
      if (m_acc) begin
        if (m_init) begin
          m_h = int'(hs.heading_in); m_ov = 1'b1; m_init = 1'b0;
        end else begin
          m_pend = smooth(m_h, int'(hs.heading_in)); m_busy = 2;
        end
      end
      if (m_acc) m_cnt = 0;
      else if (m_cnt < T) m_cnt++;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("heading_out", int'(hs.heading_out), m_h);
      check("out_valid", int'(hs.out_valid), int'(m_ov));
      check("in_ready", int'(hs.in_ready), int'(m_busy == 0));
      check("stale", int'(hs.stale), int'(m_cnt == T));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pulse(input int h);
    hs.heading_valid = 1'b1;
    hs.heading_in    = 9'(h);
    cyc(1);
    hs.heading_valid = 1'b0;
  endtask

  task automatic do_reset;
    rst = 1'b1; cyc(1); rst = 1'b0;
  endtask

  // Normal-path sample: result must show two cycles after the accept
  task automatic send(input int h, input int exp);
    pulse(h);
    check("busy_in_diff", int'(hs.in_ready), 0);
    cyc(1);
    check("lit_heading", int'(hs.heading_out), exp);
    check("lit_out_valid", int'(hs.out_valid), 1);
    cyc(1);
  endtask

  initial begin
    hs.heading_valid = 1'b0;
    hs.heading_in    = '0;
    cyc(2);
    check("rst_heading", int'(hs.heading_out), 0);
    check("rst_out_valid", int'(hs.out_valid), 0);
    check("rst_stale", int'(hs.stale), 0);
    check("rst_in_ready", int'(hs.in_ready), 1);
    rst = 1'b0;
    chk_en = 1'b1;

    // First sample loads directly, then EMA step of 5
    pulse(100);
    check("init_heading", int'(hs.heading_out), 100);
    check("init_out_valid", int'(hs.out_valid), 1);
    send(120, 105);

    // Forward and backward wrap
    do_reset; pulse(350);
    send(10, 355); send(10, 358); send(10, 1);
    do_reset; pulse(2);
    send(342, 357);

    // Deadband, minimum step, +180 folding to -180
    do_reset; pulse(100);
    send(101, 100); send(102, 101); send(281, 56);

    // Out-of-range sample dropped
    pulse(400);
    check("oor_out_valid", int'(hs.out_valid), 0);
    check("oor_heading", int'(hs.heading_out), 56);
    check("oor_ready", int'(hs.in_ready), 1);

    // Sample during DIFF ignored
    pulse(200);
    check("diff_not_ready", int'(hs.in_ready), 0);
    pulse(50);
    check("ign_heading", int'(hs.heading_out), 92);
    cyc(1);
    check("ign_no_pulse", int'(hs.out_valid), 0);
    check("ign_heading_hold", int'(hs.heading_out), 92);

    // Timeout
    pulse(90);
    cyc(49);
    check("stale_early", int'(hs.stale), 0);
    cyc(1);
    check("stale_at_T", int'(hs.stale), 1);
    pulse(400);
    check("stale_oor_keeps", int'(hs.stale), 1);
    pulse(10);
    check("stale_clear", int'(hs.stale), 0);
    cyc(2);

    // Reset during UPDATE
    pulse(30);
    cyc(1);
    rst = 1'b1; #1;
    check("midrst_heading", int'(hs.heading_out), 0);
    check("midrst_out_valid", int'(hs.out_valid), 0);
    check("midrst_ready", int'(hs.in_ready), 1);
    cyc(1);
    rst = 1'b0;
    pulse(200);
    check("postrst_heading", int'(hs.heading_out), 200);
    check("postrst_out_valid", int'(hs.out_valid), 1);

    // Random traffic, occasional short resets, headings biased near wrap
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 149) == 0) begin
        rst = 1'b1; #2; rst = 1'b0;
      end
      hs.heading_valid = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0)
        hs.heading_in = 9'(($urandom_range(0, 1) == 0) ? $urandom_range(340, 359) : $urandom_range(0, 20));
      else
        hs.heading_in = 9'($urandom_range(0, 399));
      cyc(1);
    end
    hs.heading_valid = 1'b0;
    cyc(60);

    chk_en = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
